nibble_serial_add_ctrl: RTL

Multi-cycle controller that sequences a single 4-bit carry-lookahead adder slice across a WIDTH-bit operand pair, one nibble per clock, LSB nibble first. The nibble carry-out is registered between cycles. The block gives the processor datapath a low-area WIDTH-bit adder with a start/done handshake. The 4-bit CLA slice is instantiated inside this block; no other adder is used.

---
 rtl/nibble_serial_add_ctrl.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/nibble_serial_add_ctrl.sv
// rtl/nibble_serial_add_ctrl.sv - WIDTH-bit adder sequencing one 4-bit CLA slice per clock; optional subtract via NSA_SUB_EN

module nibble_serial_add_ctrl_cla4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:1] c;

    // Carry-lookahead: every carry is a flat sum of generate/propagate products
    always_comb begin
        g    = a & b;
        p    = a ^ b;
        c[1] = g[0] | (p[0] & ci);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & ci);
        s    = p ^ {c[3], c[2], c[1], ci};
        co   = c[4];
    end
endmodule

module nibble_serial_add_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
`ifdef NSA_SUB_EN
    input  logic             sub,
`endif
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);
    localparam int N  = WIDTH / 4;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             c_out_q, c_out_d;
    logic             ovf_q, ovf_d;

    logic             accept;
    logic             last_step;
    logic [WIDTH-1:0] b_load;
    logic             carry_load;
    logic [3:0]       nib_sum;
    logic             nib_co;

    nibble_serial_add_ctrl_cla4 u_cla4 (
        .a  (a_sh_q[3:0]),
        .b  (b_sh_q[3:0]),
        .ci (carry_q),
        .s  (nib_sum),
        .co (nib_co)
    );

    // Operand B / carry-in selection at load time (subtract loads ~b with carry 1)
    always_comb begin
`ifdef NSA_SUB_EN
        b_load     = sub ? ~b : b;
        carry_load = sub ? 1'b1 : c_in;
`else
        b_load     = b;
        carry_load = c_in;
`endif
    end

    // State register and datapath flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            c_out_q <= c_out_d;
            ovf_q   <= ovf_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last_step) state_d = DONE;
            DONE:    state_d = start ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs decoded from state
    always_comb begin
        ready = (state_q == IDLE) || (state_q == DONE);
        busy  = (state_q == RUN);
        done  = (state_q == DONE);
        sum   = sum_q;
        c_out = c_out_q;
        ovf   = ovf_q;
    end

    // Datapath: load on accept, one nibble per RUN cycle, publish result on the last step
    always_comb begin
        accept    = start && ready;
        last_step = (state_q == RUN) && (cnt_q == LAST);
        a_sh_d    = a_sh_q;
        b_sh_d    = b_sh_q;
        acc_d     = acc_q;
        sum_d     = sum_q;
        carry_d   = carry_q;
        cnt_d     = cnt_q;
        c_out_d   = c_out_q;
        ovf_d     = ovf_q;
        if (accept) begin
            a_sh_d  = a;
            b_sh_d  = b_load;
            carry_d = carry_load;
            cnt_d   = '0;
        end else if (state_q == RUN) begin
            acc_d   = {nib_sum, acc_q[WIDTH-1:4]};
            a_sh_d  = a_sh_q >> 4;
            b_sh_d  = b_sh_q >> 4;
            carry_d = nib_co;
            cnt_d   = cnt_q + CW'(1);
            if (last_step) begin
                sum_d   = acc_d;
                c_out_d = nib_co;
                // Carry into the MSB is recovered from the MSB sum bit of the final nibble
                ovf_d   = (a_sh_q[3] ^ b_sh_q[3] ^ nib_sum[3]) ^ nib_co;
            end
        end
    end
endmodule
